// File: rtl/decoder_stream_driver_pkg.sv
// Shared constants and types for the decoder stream driver.
// Also used by benches that probe the controller state.
package decoder_stream_driver_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'hA5;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_START,
    ST_SEND_HEADER,
    ST_SEND_DATA,
    ST_WAIT_RESULT,
    ST_RECV_RESULT,
    ST_REPORT,
    ST_FINISH
  } state_e;

  // Saturating increment for the 32-bit latency counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/decoder_stream_driver_if.sv
// Byte-wide valid/ready stream used for the syndrome source,
// the decoder input FIFO and the decoder output FIFO.
interface decoder_stream_driver_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/decoder_stream_driver_rx_result_parser.sv
// Result message parser: byte index, field capture, discard of trailing
// bytes, and the latency / first-byte timeout counter.
module rx_result_parser
  import decoder_stream_driver_pkg::*;
#(
  parameter int RESULT_BYTES   = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        waiting,
  input  logic        receiving,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        first_byte,
  output logic        last_byte,
  output logic        timeout,
  output logic [7:0]  iterations_d,
  output logic [15:0] cycles_d,
  output logic [31:0] latency_d
);

  localparam int               IDX_W        = $clog2(RESULT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(RESULT_BYTES - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      lat_q, lat_d;
  logic [7:0]       iterations_q;
  logic [15:0]      cycles_q;
  logic [31:0]      latency_q;

  // The *_d field outputs let the owner snapshot a complete result on the
  // same edge that accepts the final byte.
  always_comb begin
    rx_ready     = waiting | receiving;
    first_byte   = waiting & rx_valid;
    last_byte    = receiving & rx_valid & (idx_q == LAST_IDX);
    timeout      = waiting & ~rx_valid & (lat_q == TIMEOUT_LAST);
    idx_d        = idx_q;
    lat_d        = lat_q;
    iterations_d = iterations_q;
    cycles_d     = cycles_q;
    latency_d    = latency_q;

    if (arm) begin
      idx_d = '0;
      lat_d = '0;
    end else if (waiting) begin
      lat_d = sat_inc32(lat_q);
      if (rx_valid) begin
        iterations_d = rx_data;
        latency_d    = sat_inc32(lat_q);
        idx_d        = IDX_W'(1);
      end
    end else if (receiving && rx_valid) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == IDX_W'(1)) begin
        cycles_d[15:8] = rx_data;
      end else if (idx_q == IDX_W'(2)) begin
        cycles_d[7:0] = rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      lat_q        <= '0;
      iterations_q <= '0;
      cycles_q     <= '0;
      latency_q    <= '0;
    end else begin
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      iterations_q <= iterations_d;
      cycles_q     <= cycles_d;
      latency_q    <= latency_d;
    end
  end

endmodule

// File: rtl/decoder_stream_driver.sv
// Host-side controller framing syndrome bytes into the decoder byte
// protocol and collecting one fixed-length result per test.
module decoder_stream_driver
  import decoder_stream_driver_pkg::*;
#(
  parameter int BYTES_PER_ROUND = 23,
  parameter int ROUNDS          = 19,
  parameter int RESULT_BYTES    = 3,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [15:0]                    cfg_num_tests,
  decoder_stream_driver_if.slave         syn,
  decoder_stream_driver_if.master        tx,
  decoder_stream_driver_if.slave         rx,
  output logic                           busy,
  output logic                           res_valid,
  output logic [15:0]                    res_index,
  output logic [7:0]                     res_iterations,
  output logic [15:0]                    res_cycles,
  output logic [31:0]                    res_latency,
  output logic                           done,
  output logic                           err_timeout
);

  localparam int                FRAME_BYTES = BYTES_PER_ROUND * ROUNDS;
  localparam int                CNT_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(FRAME_BYTES - 1);

  state_e            state_q, state_d;
  logic [15:0]       num_tests_q, num_tests_d;
  logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;
  logic [15:0]       res_index_q, res_index_d;
  logic [7:0]        res_iterations_q, res_iterations_d;
  logic [15:0]       res_cycles_q, res_cycles_d;
  logic [31:0]       res_latency_q, res_latency_d;
  logic              err_timeout_q, err_timeout_d;

  logic              arm, waiting, receiving;
  logic              first_byte, last_byte, timeout;
  logic [7:0]        fld_iterations;
  logic [15:0]       fld_cycles;
  logic [31:0]       fld_latency;

  rx_result_parser #(
    .RESULT_BYTES   (RESULT_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_parser (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .waiting      (waiting),
    .receiving    (receiving),
    .rx_data      (rx.data),
    .rx_valid     (rx.valid),
    .rx_ready     (rx.ready),
    .first_byte   (first_byte),
    .last_byte    (last_byte),
    .timeout      (timeout),
    .iterations_d (fld_iterations),
    .cycles_d     (fld_cycles),
    .latency_d    (fld_latency)
  );

  always_comb begin
    state_d          = state_q;
    num_tests_d      = num_tests_q;
    data_cnt_d       = data_cnt_q;
    res_index_d      = res_index_q;
    res_iterations_d = res_iterations_q;
    res_cycles_d     = res_cycles_q;
    res_latency_d    = res_latency_q;
    err_timeout_d    = err_timeout_q;
    tx.data          = 8'h00;
    tx.valid         = 1'b0;
    syn.ready        = 1'b0;
    arm              = 1'b0;
    waiting          = 1'b0;
    receiving        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          num_tests_d   = cfg_num_tests;
          res_index_d   = '0;
          err_timeout_d = 1'b0;
          state_d       = ST_SEND_START;
        end
      end
      ST_SEND_START: begin
        tx.data  = START_DECODING_MSG;
        tx.valid = 1'b1;
        if (tx.ready) state_d = ST_SEND_HEADER;
      end
      ST_SEND_HEADER: begin
        tx.data    = MEASUREMENT_DATA_HEADER;
        tx.valid   = 1'b1;
        data_cnt_d = '0;
        if (tx.ready) state_d = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        // Zero-latency pass-through from syndrome source to decoder FIFO.
        tx.data   = syn.data;
        tx.valid  = syn.valid;
        syn.ready = tx.ready;
        if (syn.valid && tx.ready) begin
          data_cnt_d = data_cnt_q + CNT_W'(1);
          if (data_cnt_q == LAST_CNT) begin
            arm     = 1'b1;
            state_d = ST_WAIT_RESULT;
          end
        end
      end
      ST_WAIT_RESULT: begin
        waiting = 1'b1;
        if (first_byte) begin
          state_d = ST_RECV_RESULT;
        end else if (timeout) begin
          err_timeout_d = 1'b1;
          state_d       = ST_FINISH;
        end
      end
      ST_RECV_RESULT: begin
        receiving = 1'b1;
        if (last_byte) begin
          res_iterations_d = fld_iterations;
          res_cycles_d     = fld_cycles;
          res_latency_d    = fld_latency;
          state_d          = ST_REPORT;
        end
      end
      ST_REPORT: begin
        res_index_d = res_index_q + 16'd1;
        if (num_tests_q != 16'd0 && (res_index_q + 16'd1) == num_tests_q) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_SEND_HEADER;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      num_tests_q      <= '0;
      data_cnt_q       <= '0;
      res_index_q      <= '0;
      res_iterations_q <= '0;
      res_cycles_q     <= '0;
      res_latency_q    <= '0;
      err_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      num_tests_q      <= num_tests_d;
      data_cnt_q       <= data_cnt_d;
      res_index_q      <= res_index_d;
      res_iterations_q <= res_iterations_d;
      res_cycles_q     <= res_cycles_d;
      res_latency_q    <= res_latency_d;
      err_timeout_q    <= err_timeout_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign res_valid      = (state_q == ST_REPORT);
  assign done           = (state_q == ST_FINISH);
  assign res_index      = res_index_q;
  assign res_iterations = res_iterations_q;
  assign res_cycles     = res_cycles_q;
  assign res_latency    = res_latency_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: doc/decoder_stream_driver.md
# decoder_stream_driver

Synthesizable host-side controller that frames syndrome data into the Helios single-FPGA decoder's byte protocol and parses its result messages. It sends one start-decoding message per session, then a measurement header plus BYTES_PER_ROUND×ROUNDS syndrome bytes per test, and collects a fixed-length result per test. It sits between a syndrome byte source (DMA or on-chip ROM) and the decoder's input/output FIFOs. It replaces bench-only loading logic so that multi-test runs, timeouts and latency measurement work on hardware.

## Interface
- BYTES_PER_ROUND, default 23: bytes per measurement round (⌈X·Z/8⌉; d=19).
- ROUNDS, default 19: measurement rounds per test.
- RESULT_BYTES, default 3: bytes per result message (≥3).
- TIMEOUT_CYCLES, default 65535: maximum wait for the first result byte.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a session when the block is idle.
- abort  in  1  returns the block to IDLE at the next edge.
- cfg_num_tests  in  16  number of tests per session; 0 means continuous. Sampled on start.
- syn_data / syn_valid / syn_ready  in/in/out  8/1/1  syndrome byte source.
- tx_data / tx_valid / tx_ready  out/out/in  8/1/1  to the decoder input FIFO.
- rx_data / rx_valid / rx_ready  in/in/out  8/1/1  from the decoder output FIFO.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  one-cycle pulse carrying one result.
- res_index  out  16  test index, starting at 0.
- res_iterations  out  8  result byte 0.
- res_cycles  out  16  {byte1, byte2}.
- res_latency  out  32  cycles from the last syndrome byte accepted to the first rx byte.
- done  out  1  one-cycle pulse at session end.
- err_timeout  out  1  sticky error; cleared by start or reset.

## Operation
- States: IDLE → SEND_START → SEND_HEADER → SEND_DATA → WAIT_RESULT → RECV_RESULT → REPORT → (SEND_HEADER | FINISH) → IDLE.
- IDLE: when start=1, latch cfg_num_tests, clear res_index and err_timeout, and go to SEND_START. start while busy is ignored.
- SEND_START: tx_valid=1, tx_data=START_DECODING_MSG. Advance on tx_valid&tx_ready.
- SEND_HEADER: tx_data=MEASUREMENT_DATA_HEADER, same handshake. Clear the byte counter.
- SEND_DATA: combinational pass-through: tx_data=syn_data, tx_valid=syn_valid, syn_ready=tx_ready.
  - Count transfers.
  - The transfer with count = BYTES_PER_ROUND·ROUNDS−1 moves to WAIT_RESULT and clears the latency counter.
  - syn_ready=0 in every other state.
- WAIT_RESULT: rx_ready=1.
  - The latency counter increments each cycle and saturates at 2³²−1.
  - rx_valid=1 captures byte 0 into iterations and moves to RECV_RESULT.
  - If the counter reaches TIMEOUT_CYCLES first: set err_timeout and go to FINISH.
- RECV_RESULT: rx_ready=1.
  - Byte 1 → cycles[15:8], byte 2 → cycles[7:0].
  - Bytes 3..RESULT_BYTES−1 are accepted and discarded.
  - Accepting the last byte moves to REPORT.
- REPORT: res_valid=1 for exactly one cycle, then res_index increments (wraps at 16 bits).
  - If cfg_num_tests≠0 and res_index+1 == cfg_num_tests: go to FINISH.
  - Otherwise go to SEND_HEADER. START is not resent.
- FINISH: done=1 for one cycle, then IDLE.
- abort, or reset, in any state: go to IDLE. tx_valid, syn_ready and rx_ready drop the next cycle. A partial frame is not completed.
- Reset values: all outputs 0 (including err_timeout); res_* registers 0; state IDLE.

## Timing
- start at edge N → tx_valid=1 from cycle N+1.
- Header and start bytes are held on tx_data until accepted. tx_valid never drops before acceptance except on abort or reset.
- SEND_DATA adds zero latency: syndrome bytes move at one byte per cycle when both sides are ready.
- res_* fields are registered. They are stable from the REPORT cycle until the next REPORT.
- Minimum per-test overhead after the data phase is 1 (header) + RESULT_BYTES + 1 (REPORT) cycles, plus decoder time.
- err_timeout and done are asserted on the same FINISH cycle on a timeout.
- Simultaneous abort and start: abort wins.

## Structure
- START_DECODING_MSG and MEASUREMENT_DATA_HEADER stay in the shared parameters package. The state enum typedef is added there too, so benches can probe the state.
- One sub-module: rx_result_parser, which holds the byte index, field capture, discard of extra bytes and the latency/timeout counter. The top module holds the tx FSM.

## Test plan
- BYTES_PER_ROUND=2, ROUNDS=3, cfg_num_tests=1, syndrome bytes 01..06, rx 05,01,2C → tx stream FF-hdr? no: START, HEADER, 01..06; one res_valid with index 0, iterations 5, cycles 300; done one cycle later.
- cfg_num_tests=3 with tx_ready toggling 1/0 → exactly one START and three HEADERs; no data byte is lost or duplicated; res_index 0,1,2.
- TIMEOUT_CYCLES=10 with no rx → err_timeout=1 and done 11 cycles after the last data byte; no res_valid.
- RESULT_BYTES=5, rx 07,00,10,AA,BB → iterations 7, cycles 16; the 0xAA and 0xBB bytes are consumed; the next test starts cleanly.
- abort asserted mid-SEND_DATA (after 3 bytes) → busy=0, tx_valid=0 next cycle; a subsequent start sends START again.
- cfg_num_tests=0 for 70000 synthetic tests → res_index wraps FFFF→0000 and no done is asserted until abort.
